// File: rtl/dbus_interconnect_if.sv
// CPU data port and shared slave bus of the data-bus interconnect.
interface dbus_interconnect_if #(
  parameter int NUM_SLAVES = 8,
  parameter int SLAVE_AW   = 16
);
  logic                     dmem_rd;
  logic [31:0]              dmem_raddr;
  logic [31:0]              dmem_rdata;
  logic                     dmem_wr;
  logic [31:0]              dmem_waddr;
  logic [31:0]              dmem_wdata;
  logic [3:0]               dmem_wstrb;
  logic                     bus_stall;
  logic [NUM_SLAVES-1:0]    slave_rd;
  logic [SLAVE_AW-1:0]      slave_raddr;
  logic [NUM_SLAVES*32-1:0] slave_rdata;
  logic [NUM_SLAVES-1:0]    slave_rready;
  logic [NUM_SLAVES-1:0]    slave_wr;
  logic [SLAVE_AW-1:0]      slave_waddr;
  logic [31:0]              slave_wdata;
  logic [3:0]               slave_wstrb;
  logic                     err_valid;
  logic [1:0]               err_type;
  logic [31:0]              err_addr;
  logic                     err_clr;

  // Handshake: a read is accepted in a cycle with dmem_rd=1 and bus_stall=0; its data is on
  // dmem_rdata in the first later cycle with bus_stall=0, and the CPU holds dmem_rd while stalled.
  modport master (
    output dmem_rd, dmem_raddr, dmem_wr, dmem_waddr, dmem_wdata, dmem_wstrb, err_clr,
           slave_rdata, slave_rready,
    input  dmem_rdata, bus_stall, slave_rd, slave_raddr, slave_wr, slave_waddr,
           slave_wdata, slave_wstrb, err_valid, err_type, err_addr
  );

  modport slave (
    input  dmem_rd, dmem_raddr, dmem_wr, dmem_waddr, dmem_wdata, dmem_wstrb, err_clr,
           slave_rdata, slave_rready,
    output dmem_rdata, bus_stall, slave_rd, slave_raddr, slave_wr, slave_waddr,
           slave_wdata, slave_wstrb, err_valid, err_type, err_addr
  );
endinterface

// File: rtl/dbus_interconnect.sv
// Data-bus interconnect: address decode, stalling read path with timeout,
// combinational write path and sticky first-error capture.
module dbus_interconnect #(
  parameter int                                   NUM_SLAVES     = 8,
  parameter int                                   BASEADDR_WIDTH = 8,
  parameter int                                   SLAVE_AW       = 16,
  parameter logic [NUM_SLAVES*BASEADDR_WIDTH-1:0] BASEADDRS      = 64'h0706050403020100,
  parameter logic [31:0]                          DEFAULT_RDATA  = 32'hDEAD_BEEF,
  parameter int                                   TIMEOUT        = 15
) (
  input  logic               clk,
  input  logic               rst,
  dbus_interconnect_if.slave bus,
  output logic               dbg_state_o
);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            unmapped_q, unmapped_d;
  logic [31:0]     raddr_q, raddr_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            err_valid_q, err_valid_d;
  logic [1:0]      err_type_q, err_type_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic [NUM_SLAVES-1:0] rd_oh, wr_oh;
  logic [31:0]           rdata;
  logic                  stall, done, accept, rd_err, wr_err;
  logic [1:0]            rd_err_type;

  // Lowest index wins on overlapping base tags.
  function automatic logic [NUM_SLAVES-1:0] decode(input logic [31:0] addr);
    logic [NUM_SLAVES-1:0] oh;
    oh = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (addr[31 -: BASEADDR_WIDTH] == BASEADDRS[i*BASEADDR_WIDTH +: BASEADDR_WIDTH]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [SW-1:0] onehot_idx(input logic [NUM_SLAVES-1:0] oh);
    logic [SW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (oh[i]) idx = SW'(i);
    end
    return idx;
  endfunction

  assign rd_oh = decode(bus.dmem_raddr);
  assign wr_oh = decode(bus.dmem_waddr);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    unmapped_d  = unmapped_q;
    raddr_d     = raddr_q;
    wait_d      = wait_q;
    rdata       = '0;
    stall       = 1'b0;
    done        = 1'b0;
    rd_err      = 1'b0;
    rd_err_type = 2'b00;
    if (state_q == S_PEND) begin
      if (unmapped_q) begin
        rdata       = DEFAULT_RDATA;
        done        = 1'b1;
        rd_err      = 1'b1;
        rd_err_type = 2'b01;
      end else if (bus.slave_rready[sel_q]) begin
        rdata = bus.slave_rdata[{sel_q, 5'd0} +: 32];
        done  = 1'b1;
      end else if (wait_q == TMO) begin
        rdata       = DEFAULT_RDATA;
        done        = 1'b1;
        rd_err      = 1'b1;
        rd_err_type = 2'b11;
      end else begin
        stall  = 1'b1;
        wait_d = wait_q + CW'(1);
      end
    end
    // A new request may be accepted in the same cycle the previous one completes.
    accept = bus.dmem_rd & ~stall;
    if (accept) begin
      state_d    = S_PEND;
      sel_d      = onehot_idx(rd_oh);
      unmapped_d = ~|rd_oh;
      raddr_d    = bus.dmem_raddr;
      wait_d     = '0;
    end else if (done) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    wr_err      = bus.dmem_wr & ~|wr_oh;
    err_valid_d = err_valid_q;
    err_type_d  = err_type_q;
    err_addr_d  = err_addr_q;
    if (bus.err_clr) begin
      err_valid_d = 1'b0;
      err_type_d  = 2'b00;
      err_addr_d  = '0;
    end else if (!err_valid_q) begin
      if (rd_err) begin
        err_valid_d = 1'b1;
        err_type_d  = rd_err_type;
        err_addr_d  = raddr_q;
      end else if (wr_err) begin
        err_valid_d = 1'b1;
        err_type_d  = 2'b10;
        err_addr_d  = bus.dmem_waddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      unmapped_q  <= 1'b0;
      raddr_q     <= '0;
      wait_q      <= '0;
      err_valid_q <= 1'b0;
      err_type_q  <= 2'b00;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      unmapped_q  <= unmapped_d;
      raddr_q     <= raddr_d;
      wait_q      <= wait_d;
      err_valid_q <= err_valid_d;
      err_type_q  <= err_type_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.dmem_rdata  = rdata;
  assign bus.bus_stall   = stall;
  assign bus.slave_rd    = accept ? rd_oh : '0;
  assign bus.slave_raddr = bus.dmem_raddr[SLAVE_AW-1:0];
  assign bus.slave_wr    = bus.dmem_wr ? wr_oh : '0;
  assign bus.slave_waddr = bus.dmem_waddr[SLAVE_AW-1:0];
  assign bus.slave_wdata = bus.dmem_wdata;
  assign bus.slave_wstrb = bus.dmem_wstrb;
  assign bus.err_valid   = err_valid_q;
  assign bus.err_type    = err_type_q;
  assign bus.err_addr    = err_addr_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_dbus_interconnect.sv
// Bench for dbus_interconnect: directed and randomized reads/writes checked against a
// transaction-level model of decode, stall, timeout and first-error capture.
module tb_dbus_interconnect;
  localparam int          NS    = 8;
  localparam int          AW    = 16;
  localparam int          TMO   = 15;
  localparam logic [31:0] DEF   = 32'hDEAD_BEEF;
  // Slave 7 shares tag 0x01 with slave 1, so 0x07 is unmapped and 0x01 must pick slave 1.
  localparam logic [63:0] BASES = 64'h01_06_05_04_03_02_01_00;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [31:0] slv_data [NS];
  int          tag_tbl  [NS] = '{0, 1, 2, 3, 4, 5, 6, 1};
  logic [31:0] exp_q [$];

  logic        exp_ev;
  logic [1:0]  exp_et;
  logic [31:0] exp_ea;

  dbus_interconnect_if #(.NUM_SLAVES(NS), .SLAVE_AW(AW)) bus ();

  dbus_interconnect #(
    .NUM_SLAVES(NS), .BASEADDR_WIDTH(8), .SLAVE_AW(AW), .BASEADDRS(BASES),
    .DEFAULT_RDATA(DEF), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < NS; g++) begin : g_pack
    assign bus.slave_rdata[g*32 +: 32] = slv_data[g];
  end

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if (int'(a[31:24]) == tag_tbl[i]) return i;
    return -1;
  endfunction

  function automatic logic [NS-1:0] ref_onehot(input int idx);
    logic [NS-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic void ref_err(input bit clr, input bit rd_err, input logic [1:0] rt,
                                  input logic [31:0] ra, input bit wr_err, input logic [31:0] wa);
    if (clr) begin
      exp_ev = 1'b0; exp_et = 2'b00; exp_ea = '0;
    end else if (!exp_ev) begin
      if (rd_err) begin
        exp_ev = 1'b1; exp_et = rt; exp_ea = ra;
      end else if (wr_err) begin
        exp_ev = 1'b1; exp_et = 2'b10; exp_ea = wa;
      end
    end
  endfunction

  task automatic idle_inputs();
    bus.dmem_rd      = 1'b0;
    bus.dmem_raddr   = '0;
    bus.dmem_wr      = 1'b0;
    bus.dmem_waddr   = '0;
    bus.dmem_wdata   = '0;
    bus.dmem_wstrb   = '0;
    bus.slave_rready = '1;
    bus.err_clr      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({bus.bus_stall, bus.dmem_rdata} !== 33'd0)
      $display("FAIL reset_out got stall=%b rdata=%h want 0/00000000", bus.bus_stall, bus.dmem_rdata);
    else pass_cnt++;
    total_cnt++;
    if ({bus.err_valid, bus.err_type, bus.err_addr} !== 35'd0)
      $display("FAIL reset_err got %b/%b/%h want 0/00/00000000", bus.err_valid, bus.err_type, bus.err_addr);
    else pass_cnt++;
    total_cnt++;
    if ({bus.slave_rd, bus.slave_wr} !== 16'd0)
      $display("FAIL reset_strobes got rd=%b wr=%b want 0/0", bus.slave_rd, bus.slave_wr);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    ref_err(1'b1, 1'b0, 2'b00, '0, 1'b0, '0);
  endtask

  // Directed latency/timeout/overlap cases followed by randomized transactions.
  task automatic test_reads();
    logic [31:0] dir_addr [6] = '{32'h0100_0010, 32'h0300_0020, 32'h0200_0030,
                                  32'h0500_0040, 32'h0700_0000, 32'h0100_0000};
    int          dir_dly  [6] = '{0, 3, 1000, 15, 0, 2};
    logic [31:0] addr, waddr, wdata, r, e_data;
    logic [7:0]  tagb;
    logic [3:0]  wstrb;
    logic [1:0]  e_rt;
    int          d, s, ws, k, t, stalls;
    bit          wr, clr, done, e_stall, e_rerr;
    for (int i = 0; i < NS; i++) slv_data[i] = $urandom();
    for (int n = 0; n < 6 + 30; n++) begin
      if (n < 6) begin
        addr = dir_addr[n]; d = dir_dly[n]; wr = 1'b0; clr = 1'b0; waddr = '0;
      end else begin
        t = $urandom_range(0, 9);
        tagb = (t == 8) ? 8'hFE : (t == 9) ? 8'h07 : 8'(t);
        r = $urandom(); addr = {tagb, r[23:0]};
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 5);
        wr = 1'($urandom_range(0, 1));
        clr = ($urandom_range(0, 3) == 0);
        t = $urandom_range(0, 8);
        tagb = (t == 8) ? 8'hFF : 8'(t);
        r = $urandom(); waddr = {tagb, r[23:0]};
      end
      wdata = $urandom(); wstrb = 4'($urandom_range(0, 15));
      s = ref_decode(addr);
      ws = ref_decode(waddr);

      @(negedge clk);
      bus.dmem_rd = 1'b1; bus.dmem_raddr = addr;
      bus.slave_rready = '1;
      if (s >= 0 && d > 0) bus.slave_rready[s] = 1'b0;
      bus.dmem_wr = wr; bus.dmem_waddr = waddr; bus.dmem_wdata = wdata; bus.dmem_wstrb = wstrb;
      bus.err_clr = clr;
      #1;
      total_cnt++;
      if ({bus.err_valid, bus.err_type, bus.err_addr} !== {exp_ev, exp_et, exp_ea})
        $display("FAIL err_t0 n=%0d got %b/%b/%h want %b/%b/%h", n, bus.err_valid, bus.err_type,
                 bus.err_addr, exp_ev, exp_et, exp_ea);
      else pass_cnt++;
      total_cnt++;
      if ({bus.slave_rd, bus.slave_raddr, bus.bus_stall} !== {ref_onehot(s), addr[AW-1:0], 1'b0})
        $display("FAIL rd_req n=%0d got rd=%b raddr=%h stall=%b want rd=%b raddr=%h stall=0", n,
                 bus.slave_rd, bus.slave_raddr, bus.bus_stall, ref_onehot(s), addr[AW-1:0]);
      else pass_cnt++;
      total_cnt++;
      if ({bus.slave_wr, bus.slave_waddr, bus.slave_wdata, bus.slave_wstrb} !==
          {(wr ? ref_onehot(ws) : 8'd0), waddr[AW-1:0], wdata, wstrb})
        $display("FAIL wr_path n=%0d got wr=%b waddr=%h wdata=%h wstrb=%b want wr=%b waddr=%h wdata=%h wstrb=%b",
                 n, bus.slave_wr, bus.slave_waddr, bus.slave_wdata, bus.slave_wstrb,
                 (wr ? ref_onehot(ws) : 8'd0), waddr[AW-1:0], wdata, wstrb);
      else pass_cnt++;
      ref_err(clr, 1'b0, 2'b00, '0, wr && ws < 0, waddr);

      k = 0; done = 1'b0; stalls = 0;
      while (!done) begin
        @(negedge clk);
        bus.dmem_wr = 1'b0; bus.err_clr = 1'b0;
        if (s >= 0) bus.slave_rready[s] = (k >= d);
        e_stall = 1'b0; e_rerr = 1'b0; e_rt = 2'b00; e_data = '0;
        if (s < 0) begin
          e_data = DEF; e_rerr = 1'b1; e_rt = 2'b01; done = 1'b1;
        end else if (k >= d) begin
          e_data = slv_data[s]; done = 1'b1;
        end else if (k == TMO) begin
          e_data = DEF; e_rerr = 1'b1; e_rt = 2'b11; done = 1'b1;
        end else begin
          e_stall = 1'b1; stalls++;
        end
        // The CPU keeps asking while stalled; those requests must not reach a slave.
        bus.dmem_rd = e_stall; bus.dmem_raddr = $urandom();
        #1;
        total_cnt++;
        if ({bus.bus_stall, bus.dmem_rdata} !== {e_stall, e_data})
          $display("FAIL rd_data n=%0d k=%0d got stall=%b rdata=%h want stall=%b rdata=%h", n, k,
                   bus.bus_stall, bus.dmem_rdata, e_stall, e_data);
        else pass_cnt++;
        total_cnt++;
        if (bus.slave_rd !== 8'd0)
          $display("FAIL rd_ignored n=%0d k=%0d got slave_rd=%b want 00000000", n, k, bus.slave_rd);
        else pass_cnt++;
        if (k > 0) begin
          total_cnt++;
          if ({bus.err_valid, bus.err_type, bus.err_addr} !== {exp_ev, exp_et, exp_ea})
            $display("FAIL err_dp n=%0d k=%0d got %b/%b/%h want %b/%b/%h", n, k, bus.err_valid,
                     bus.err_type, bus.err_addr, exp_ev, exp_et, exp_ea);
          else pass_cnt++;
        end
        ref_err(1'b0, e_rerr, e_rt, addr, 1'b0, '0);
        k++;
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total_cnt++;
    if ({bus.bus_stall, bus.dmem_rdata} !== 33'd0)
      $display("FAIL rd_idle got stall=%b rdata=%h want 0/00000000", bus.bus_stall, bus.dmem_rdata);
    else pass_cnt++;
  endtask

  task automatic test_unmapped_errors();
    @(negedge clk); idle_inputs(); bus.err_clr = 1'b1;
    @(negedge clk); idle_inputs();
    bus.dmem_wr = 1'b1; bus.dmem_waddr = 32'hFF00_0004; bus.dmem_wdata = $urandom(); bus.dmem_wstrb = 4'hF;
    #1;
    total_cnt++;
    if (bus.slave_wr !== 8'd0) $display("FAIL unm_wr got slave_wr=%b want 00000000", bus.slave_wr);
    else pass_cnt++;
    @(negedge clk); idle_inputs();
    bus.dmem_rd = 1'b1; bus.dmem_raddr = 32'hFE00_0000;
    #1;
    total_cnt++;
    if ({bus.slave_rd, bus.bus_stall} !== 9'd0)
      $display("FAIL unm_rd_req got rd=%b stall=%b want 0/0", bus.slave_rd, bus.bus_stall);
    else pass_cnt++;
    total_cnt++;
    if ({bus.err_valid, bus.err_type, bus.err_addr} !== {1'b1, 2'b10, 32'hFF00_0004})
      $display("FAIL unm_wr_err got %b/%b/%h want 1/10/ff000004", bus.err_valid, bus.err_type, bus.err_addr);
    else pass_cnt++;
    @(negedge clk); idle_inputs();
    #1;
    total_cnt++;
    if ({bus.bus_stall, bus.dmem_rdata} !== {1'b0, DEF})
      $display("FAIL unm_rd_data got stall=%b rdata=%h want 0/%h", bus.bus_stall, bus.dmem_rdata, DEF);
    else pass_cnt++;
    @(negedge clk); idle_inputs();
    #1;
    total_cnt++;
    if ({bus.err_valid, bus.err_type, bus.err_addr} !== {1'b1, 2'b10, 32'hFF00_0004})
      $display("FAIL first_err_wins got %b/%b/%h want 1/10/ff000004", bus.err_valid, bus.err_type, bus.err_addr);
    else pass_cnt++;
    // Clear in the same cycle as another unmapped write: the clear must win.
    @(negedge clk); idle_inputs();
    bus.err_clr = 1'b1; bus.dmem_wr = 1'b1; bus.dmem_waddr = 32'hFF00_0008;
    @(negedge clk); idle_inputs();
    #1;
    total_cnt++;
    if ({bus.err_valid, bus.err_type, bus.err_addr} !== 35'd0)
      $display("FAIL err_clr got %b/%b/%h want 0/00/00000000", bus.err_valid, bus.err_type, bus.err_addr);
    else pass_cnt++;
    @(negedge clk); idle_inputs();
    bus.dmem_rd = 1'b1; bus.dmem_raddr = 32'hFE00_0000;
    @(negedge clk); idle_inputs();
    bus.dmem_wr = 1'b1; bus.dmem_waddr = 32'hFF00_000C;
    @(negedge clk); idle_inputs();
    #1;
    total_cnt++;
    if ({bus.err_valid, bus.err_type, bus.err_addr} !== {1'b1, 2'b01, 32'hFE00_0000})
      $display("FAIL rd_err_priority got %b/%b/%h want 1/01/fe000000", bus.err_valid, bus.err_type, bus.err_addr);
    else pass_cnt++;
    exp_ev = 1'b1; exp_et = 2'b01; exp_ea = 32'hFE00_0000;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h0000_0100, 32'h0100_0104, 32'h0000_0108};
    logic [31:0] wd, e_data;
    logic [3:0]  ws;
    for (int i = 0; i < NS; i++) slv_data[i] = $urandom();
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); idle_inputs();
      wd = $urandom(); ws = 4'($urandom_range(1, 15));
      if (c < 3) begin
        bus.dmem_rd = 1'b1; bus.dmem_raddr = addrs[c];
        bus.dmem_wr = 1'b1; bus.dmem_waddr = 32'h0400_0000 + 32'(c * 4);
        bus.dmem_wdata = wd; bus.dmem_wstrb = ws;
      end
      #1;
      if (c > 0) begin
        e_data = exp_q.pop_front();
        total_cnt++;
        if ({bus.bus_stall, bus.dmem_rdata} !== {1'b0, e_data})
          $display("FAIL b2b_data c=%0d got stall=%b rdata=%h want 0/%h", c, bus.bus_stall, bus.dmem_rdata, e_data);
        else pass_cnt++;
      end
      if (c < 3) begin
        total_cnt++;
        if (bus.slave_rd !== ref_onehot(ref_decode(addrs[c])))
          $display("FAIL b2b_rd c=%0d got %b want %b", c, bus.slave_rd, ref_onehot(ref_decode(addrs[c])));
        else pass_cnt++;
        exp_q.push_back(slv_data[ref_decode(addrs[c])]);
        total_cnt++;
        if ({bus.slave_wr, bus.slave_wstrb, bus.slave_wdata} !== {8'b0001_0000, ws, wd})
          $display("FAIL b2b_wr c=%0d got wr=%b wstrb=%b wdata=%h want 00010000/%b/%h", c,
                   bus.slave_wr, bus.slave_wstrb, bus.slave_wdata, ws, wd);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk); idle_inputs();
    bus.dmem_rd = 1'b1; bus.dmem_raddr = 32'h0200_0000; bus.slave_rready[2] = 1'b0;
    #1;
    total_cnt++;
    if ({bus.err_valid, bus.err_type, bus.err_addr} !== {exp_ev, exp_et, exp_ea})
      $display("FAIL pre_rst_err got %b/%b/%h want %b/%b/%h", bus.err_valid, bus.err_type,
               bus.err_addr, exp_ev, exp_et, exp_ea);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bus.dmem_rd = 1'b0;
      #1;
      total_cnt++;
      if (bus.bus_stall !== 1'b1) $display("FAIL mid_stall c=%0d got stall=%b want 1", c, bus.bus_stall);
      else pass_cnt++;
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; bus.slave_rready[2] = 1'b1;
    #1;
    total_cnt++;
    if ({bus.bus_stall, bus.dmem_rdata} !== 33'd0)
      $display("FAIL rst_stall got stall=%b rdata=%h want 0/00000000", bus.bus_stall, bus.dmem_rdata);
    else pass_cnt++;
    total_cnt++;
    if ({bus.err_valid, bus.err_type, bus.err_addr} !== 35'd0)
      $display("FAIL rst_err got %b/%b/%h want 0/00/00000000", bus.err_valid, bus.err_type, bus.err_addr);
    else pass_cnt++;
    ref_err(1'b1, 1'b0, 2'b00, '0, 1'b0, '0);
    @(negedge clk);
    #1;
    total_cnt++;
    if ({bus.bus_stall, bus.dmem_rdata, bus.slave_rd} !== 41'd0)
      $display("FAIL late_rready got stall=%b rdata=%h rd=%b want 0/00000000/0", bus.bus_stall,
               bus.dmem_rdata, bus.slave_rd);
    else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NS; i++) slv_data[i] = '0;
    exp_ev = 1'b0; exp_et = 2'b00; exp_ea = '0;
    test_reset();
    test_reads();
    test_unmapped_errors();
    test_back_to_back();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dbus_interconnect.md
Name: dbus_interconnect

Overview:
- Parametrised data-bus interconnect between the RISC-V data port and NUM_SLAVES memory-mapped slaves (DRAM, UART, SEG, SEC_CLK, buzzer, ...).
- Replaces the per-slave rbus/wbus instances and the hand-coded one-hot read mux with a single block.
- Adds features the per-slave wiring does not have: per-slave read-ready with CPU stall, a read timeout, and sticky decode/timeout error capture.

Parameters:
NUM_SLAVES, 8, number of slave ports (1..16)
BASEADDR_WIDTH, 8, address MSBs compared for decode (dmem_addr[31:32-BASEADDR_WIDTH])
SLAVE_AW, 16, width of offset passed to slaves (dmem_addr[SLAVE_AW-1:0])
BASEADDRS, {8'h07,...,8'h00}, packed NUM_SLAVES*BASEADDR_WIDTH; slice i = base tag of slave i
DEFAULT_RDATA, 32'hDEAD_BEEF, read data returned for unmapped or timed-out reads
TIMEOUT, 15, maximum stall cycles per read (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
dmem_rd  in  1  CPU read request
dmem_raddr  in  32  CPU read address
dmem_rdata  out  32  read data to CPU
dmem_wr  in  1  CPU write request
dmem_waddr  in  32  CPU write address
dmem_wdata  in  32  CPU write data
dmem_wstrb  in  4  CPU byte strobes
bus_stall  out  1  CPU stall (read data not yet valid)
slave_rd  out  NUM_SLAVES  one-hot read strobe
slave_raddr  out  SLAVE_AW  shared read offset
slave_rdata  in  NUM_SLAVES*32  slave i read data at [32i+31:32i]
slave_rready  in  NUM_SLAVES  slave i read data valid
slave_wr  out  NUM_SLAVES  one-hot write strobe
slave_waddr  out  SLAVE_AW  shared write offset
slave_wdata  out  32  shared write data
slave_wstrb  out  4  shared byte strobes
err_valid  out  1  sticky error flag
err_type  out  2  01 unmapped read, 10 unmapped write, 11 read timeout
err_addr  out  32  address of first captured error
err_clr  in  1  clears error capture

Behaviour:
- Reset (rst=1 at clk edge): pending=0, sel=0, wait_cnt=0, err_valid=0, err_type=0, err_addr=0. Outputs: bus_stall=0, dmem_rdata=0.
- Decode: slave i hits when the address MSBs equal BASEADDRS slice i. On overlap, the lowest index wins. No hit means unmapped.
- Write path is fully combinational:
  - slave_wr[i] = dmem_wr & hit_i.
  - slave_waddr, slave_wdata and slave_wstrb pass through regardless of hit.
- Read request phase (cycle T0): accepted when dmem_rd=1 and bus_stall=0.
  - slave_rd[i] = hit_i for one cycle; slave_raddr = dmem_raddr[SLAVE_AW-1:0].
  - Registers: pending=1, sel=hit index, unmapped flag, raddr, wait_cnt=0.
  - dmem_rd while bus_stall=1 is ignored: slave_rd is forced 0 and the CPU holds its request.
- Read data phase (T1 onward, pending=1):
  - Mapped, slave_rready[sel]=1: dmem_rdata=slave_rdata[sel], bus_stall=0, pending clears unless a new read is accepted in the same cycle (back-to-back reads give 1-cycle latency, zero stall).
  - Mapped, not ready, wait_cnt<TIMEOUT: bus_stall=1, wait_cnt++, dmem_rdata=0.
  - Mapped, not ready, wait_cnt==TIMEOUT: dmem_rdata=DEFAULT_RDATA, bus_stall=0, pending clears, timeout error raised. Maximum stall is TIMEOUT cycles.
  - Unmapped: dmem_rdata=DEFAULT_RDATA at T1, no stall, unmapped-read error raised.
  - If slave_rready rises in the cycle wait_cnt==TIMEOUT, the slave data wins and no error is raised.
- pending=0 and no read data phase: dmem_rdata=0, bus_stall=0.
- Error capture:
  - Loaded only when err_valid=0, so the first error wins. err_addr takes the raw 32-bit CPU address.
  - err_clr has priority over a same-cycle error and clears all three error fields.
  - If an unmapped write and a read error occur in the same cycle, the read error is captured.
- Read and write are independent; simultaneous dmem_rd and dmem_wr to different or the same slaves are both forwarded.
- Reset mid-stall: stall drops the next cycle and the pending read is discarded; a late slave_rready is ignored.

Test Plan:
- Read 0x0100_0010 (slave 1, always ready) -> slave_rd=8'b0000_0010 and slave_raddr=16'h0010 at T0; dmem_rdata=slave_rdata[1] at T1; bus_stall stays 0.
- Read slave 3 with rready delayed 3 cycles -> bus_stall=1 for exactly 3 cycles; data presented in the cycle rready=1; err_valid=0.
- Read slave 2 with rready never asserted -> bus_stall high for 15 cycles, then dmem_rdata=32'hDEAD_BEEF, err_valid=1, err_type=11, err_addr equals the request address.
- Write 0xFF00_0004 followed by read 0xFE00_0000 -> no slave_wr/slave_rd pulse; error captures type 10 and addr 0xFF00_0004 (first wins); read returns 32'hDEAD_BEEF with no stall. err_clr -> all error fields return to 0.
- Back-to-back reads to slaves 0, 1, 0 with simultaneous writes to slave 4 -> one datum per cycle in order; slave_wr[4] pulses with the correct wstrb.
- rst asserted during a stall -> next cycle bus_stall=0, dmem_rdata=0, err cleared; a later rready causes no output change.
